// File: rtl/seg_scan_driver.sv
// Two-digit, common-anode seven-segment scan driver.
// Samples both digit patterns and the brightness once per frame, inserts dead time
// at every digit changeover, and applies 8-level PWM dimming.
module seg_scan_driver #(
  parameter int          SLOT_CYCLES  = 25000,
  parameter int          BLANK_CYCLES = 500,
  parameter logic [7:0]  SEG_OFF      = 8'hFF
) (
  input  logic       clock50M,
  input  logic       reset,
  input  logic [7:0] d1_in,
  input  logic [7:0] d0_in,
  input  logic [2:0] bright,
  input  logic       en,
  output logic [7:0] seg,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int          CW        = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0] slotCnt_q, slotCnt_d;
  logic          sel_q, sel_d;
  logic [2:0]    pwm_q, pwm_d;
  logic [7:0]    s0_q, s0_d;
  logic [7:0]    s1_q, s1_d;
  logic [2:0]    sBright_q, sBright_d;
  logic [7:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          frameTick_q, frameTick_d;
  logic          slotWrap;
  logic          sampleNow;
  logic          digitOn;

  // The sample cycle sits at slot_cnt 0, inside the blank window, so a lit digit
  // never sees its shadow pattern change.
  always_comb begin
    slotWrap    = (slotCnt_q == SLOT_LAST);
    sampleNow   = (slotCnt_q == '0) && !sel_q;
    slotCnt_d   = slotWrap ? '0 : slotCnt_q + CW'(1);
    sel_d       = slotWrap ? ~sel_q : sel_q;
    pwm_d       = pwm_q + 3'd1;
    s0_d        = sampleNow ? d0_in  : s0_q;
    s1_d        = sampleNow ? d1_in  : s1_q;
    sBright_d   = sampleNow ? bright : sBright_q;
    frameTick_d = sampleNow;

    digitOn = en && (slotCnt_q >= BLANK_END) && (pwm_q <= sBright_q);
    an_d    = 2'b11;
    seg_d   = SEG_OFF;
    if (digitOn) begin
      if (sel_q) begin
        an_d  = 2'b01;
        seg_d = s1_q;
      end else begin
        an_d  = 2'b10;
        seg_d = s0_q;
      end
    end
  end

  always_ff @(posedge clock50M) begin
    if (!reset) begin
      slotCnt_q   <= '0;
      sel_q       <= 1'b0;
      pwm_q       <= 3'd0;
      s0_q        <= SEG_OFF;
      s1_q        <= SEG_OFF;
      sBright_q   <= 3'd7;
      seg_q       <= SEG_OFF;
      an_q        <= 2'b11;
      frameTick_q <= 1'b0;
    end else begin
      slotCnt_q   <= slotCnt_d;
      sel_q       <= sel_d;
      pwm_q       <= pwm_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      sBright_q   <= sBright_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      frameTick_q <= frameTick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frameTick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: an index-based reference model pushes the
// expected registered outputs for each edge, and they are popped after that edge.
module tb_seg_scan_driver;

  localparam int SLOT  = 16;
  localparam int BLANK = 2;
  localparam int FRAME = 2 * SLOT;

  logic       clock50M;
  logic       reset;
  logic [7:0] d1_in;
  logic [7:0] d0_in;
  logic [2:0] bright;
  logic       en;
  logic [7:0] seg;
  logic [1:0] an;
  logic       frame_tick;

  typedef struct {
    logic [7:0] seg;
    logic [1:0] an;
    logic       tick;
  } expT;

  expT sbQ[$];

  int checkCount = 0;
  int passCount  = 0;
  int cycleNum   = 0;

  // Reference model: state index since the last reset edge plus the sampled shadows.
  int         mIdx    = 0;
  logic [7:0] mS0     = 8'hFF;
  logic [7:0] mS1     = 8'hFF;
  logic [2:0] mBright = 3'd7;

  seg_scan_driver #(
    .SLOT_CYCLES (SLOT),
    .BLANK_CYCLES(BLANK),
    .SEG_OFF     (8'hFF)
  ) dut (
    .clock50M  (clock50M),
    .reset     (reset),
    .d1_in     (d1_in),
    .d0_in     (d0_in),
    .bright    (bright),
    .en        (en),
    .seg       (seg),
    .an        (an),
    .frame_tick(frame_tick)
  );

  initial begin
    clock50M = 1'b0;
    forever #10 clock50M = ~clock50M;
  end

  // Predict what the coming edge will register, push it, then take the edge.
  task automatic applyStimulus();
    expT e;
    int  slot;
    int  selv;
    bit  on;
    if (!reset) begin
      e.seg = 8'hFF; e.an = 2'b11; e.tick = 1'b0;
      mIdx = 0; mS0 = 8'hFF; mS1 = 8'hFF; mBright = 3'd7;
    end else begin
      slot = mIdx % SLOT;
      selv = (mIdx / SLOT) % 2;
      on   = en && (slot >= BLANK) && ((mIdx % 8) <= int'(mBright));
      e.an  = on ? ((selv == 1) ? 2'b01 : 2'b10) : 2'b11;
      e.seg = on ? ((selv == 1) ? mS1 : mS0) : 8'hFF;
      e.tick = ((mIdx % FRAME) == 0);
      if (e.tick) begin
        mS0 = d0_in; mS1 = d1_in; mBright = bright;
      end
      mIdx++;
    end
    sbQ.push_back(e);
    @(posedge clock50M);
    #1;
    cycleNum++;
  endtask

  task automatic checkOutput();
    expT e;
    checkCount++;
    assert (sbQ.size() > 0) passCount++;
    else $error("[TB] FAIL scoreboard_empty cyc=%0d got=0 exp>0", cycleNum);
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkCount++;
      assert (seg === e.seg) passCount++;
      else $error("[TB] FAIL seg cyc=%0d got=%h exp=%h", cycleNum, seg, e.seg);
      checkCount++;
      assert (an === e.an) passCount++;
      else $error("[TB] FAIL an cyc=%0d got=%b exp=%b", cycleNum, an, e.an);
      checkCount++;
      assert (frame_tick === e.tick) passCount++;
      else $error("[TB] FAIL frame_tick cyc=%0d got=%b exp=%b", cycleNum, frame_tick, e.tick);
      checkCount++;
      assert (an !== 2'b00) passCount++;
      else $error("[TB] FAIL an_overlap cyc=%0d got=%b exp=not00", cycleNum, an);
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus();
      checkOutput();
    end
  endtask

  // Advance until the current cycle's state index sits at the given frame phase.
  task automatic waitPhase(input int k);
    int guard = 0;
    while (((mIdx % FRAME) != k) && (guard < 2 * FRAME)) begin
      runCycles(1);
      guard++;
    end
    checkCount++;
    assert ((mIdx % FRAME) == k) passCount++;
    else $error("[TB] FAIL wait_phase got=%0d exp=%0d", mIdx % FRAME, k);
  endtask

  initial begin
    reset  = 1'b0;
    d1_in  = 8'($urandom);
    d0_in  = 8'($urandom);
    bright = 3'($urandom);
    en     = 1'($urandom);

    $display("[TB] reset held low with random inputs");
    for (int i = 0; i < 3; i++) begin
      d1_in = 8'($urandom); d0_in = 8'($urandom);
      bright = 3'($urandom); en = 1'($urandom);
      runCycles(1);
    end

    // Reset pulse high with no clock edge must leave outputs untouched.
    #3 reset = 1'b1;
    #3 reset = 1'b0;
    #2;
    checkCount++;
    assert (an === 2'b11 && seg === 8'hFF && frame_tick === 1'b0) passCount++;
    else $error("[TB] FAIL reset_no_edge got=%b/%h/%b exp=11/ff/0", an, seg, frame_tick);
    @(negedge clock50M);

    $display("[TB] basic scan");
    d1_in = 8'hF9; d0_in = 8'hC0; bright = 3'd7; en = 1'b1;
    reset = 1'b1;
    runCycles(2 * FRAME);

    $display("[TB] tear-free update mid units slot");
    waitPhase(8);
    d0_in = 8'hA4;
    runCycles(FRAME + 8);

    $display("[TB] brightness 0 then 3, with a mid-frame change");
    waitPhase(20);
    bright = 3'd0;
    runCycles(FRAME + 12);
    waitPhase(20);
    bright = 3'd3;
    waitPhase(10);
    bright = 3'd7;
    runCycles(FRAME);

    $display("[TB] enable drop and restore");
    waitPhase(6);
    en = 1'b0;
    runCycles(FRAME + 10);
    en = 1'b1;
    runCycles(10);

    $display("[TB] reset mid tens slot");
    waitPhase(20);
    reset = 1'b0;
    d1_in = 8'hB0; d0_in = 8'h92;
    runCycles(1);
    reset = 1'b1;
    runCycles(FRAME + 8);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
